run_controller: RTL and testbench
=================================

RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter PMEM_AW, default 8, program memory address width.
REQ-002 Parameter DMEM_AW, default 8, data memory address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 65535, watchdog limit on CPU run length in cycles.
REQ-004 Ports SHALL be:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  host command valid.
- CMD_READY  out  1  controller accepts a command.
- CMD_OP  in  2  command: 00 LOAD, 01 RUN, 10 PEEK, 11 NOP.
- CMD_ADDR  in  8  program or data memory address.
- CMD_DATA  in  16  instruction word for LOAD.
- RSP_VALID  out  1  one-cycle response strobe.
- RSP_DATA  out  16  response payload.
- RSP_ERR  out  1  response flags a watchdog timeout.
- CPU_START  out  1  START to the CPU control unit.
- CPU_RDY  in  1  RDY from the CPU control unit.
- PMEM_WE  out  1  program memory write enable.
- PMEM_ADDR  out  PMEM_AW  program memory address.
- PMEM_WDATA  out  16  program memory write data.
- DMEM_RE  out  1  data memory read enable; read data arrives 1 cycle later.
- DMEM_ADDR  out  DMEM_AW  data memory read address.
- DMEM_RDATA  in  8  data memory read data.
- CPU_RESET  out  1  reset request to the CPU.
- BUSY  out  1  high when the state is not IDLE.

Function
REQ-005 States SHALL be IDLE, LOAD, KICK, WAIT_LEAVE, WAIT_DONE, PEEK, PEEK_RSP, ABORT.
REQ-006 CMD_READY SHALL be 1 only in IDLE; a command transfers on a cycle with CMD_VALID=1 and CMD_READY=1.
REQ-007 Command decode from IDLE:
- LOAD SHALL go to LOAD.
- RUN SHALL go to KICK.
- PEEK SHALL go to PEEK.
- NOP SHALL stay in IDLE and give RSP_VALID=1 with RSP_DATA=0 on the next cycle.
REQ-008 LOAD SHALL last 1 cycle with PMEM_WE=1, PMEM_ADDR=CMD_ADDR, PMEM_WDATA=CMD_DATA (registered at accept), then go to IDLE with RSP_VALID=1 and RSP_DATA=CMD_DATA.
REQ-009 KICK SHALL hold CPU_START=1 until a cycle with CPU_RDY=1, then go to WAIT_LEAVE; CPU_START is 1 for exactly that one sampled cycle when CPU_RDY is already 1.
REQ-010 WAIT_LEAVE SHALL go to WAIT_DONE on the first cycle with CPU_RDY=0.
REQ-011 WAIT_DONE SHALL go to IDLE on the first cycle with CPU_RDY=1, with RSP_VALID=1, RSP_DATA=run cycle count, RSP_ERR=0.
REQ-012 Run cycle count:
- 16-bit counter, cleared on entry to KICK.
- Increments every cycle in WAIT_LEAVE and WAIT_DONE.
- Saturates at 16'hFFFF.
REQ-013 When the count reaches TIMEOUT_CYCLES in WAIT_LEAVE or WAIT_DONE, the block SHALL go to ABORT.
REQ-014 ABORT SHALL assert CPU_RESET=1 for 1 cycle, then go to IDLE with RSP_VALID=1, RSP_ERR=1, RSP_DATA=count.
REQ-015 PEEK SHALL assert DMEM_RE=1 with DMEM_ADDR=CMD_ADDR[DMEM_AW-1:0] for 1 cycle.
REQ-016 PEEK_RSP SHALL capture DMEM_RDATA, then go to IDLE with RSP_VALID=1 and RSP_DATA={8'h00,DMEM_RDATA}.
REQ-017 RSP_VALID SHALL be a single-cycle strobe with no backpressure; RSP_DATA and RSP_ERR SHALL hold until the next response.
REQ-018 Address handling:
- CMD_ADDR bits above PMEM_AW/DMEM_AW SHALL be ignored (truncation).
- Address 8'hFF is legal with no wrap side effects.
REQ-019 PMEM_WE, DMEM_RE, CPU_START and CPU_RESET SHALL never be high in the same cycle.
REQ-020 Commands presented while BUSY=1 SHALL be neither accepted nor lost; the host holds CMD_VALID.

Reset
REQ-021 RESET=1 at a rising edge SHALL force state IDLE regardless of current state, including mid-run.
REQ-022 RESET=1 SHALL clear the counter, RSP_DATA and RSP_ERR.
REQ-023 While RESET=1 and on the following cycle, all outputs SHALL be 0 except CMD_READY=1 on the following cycle.
REQ-024 RESET SHALL NOT drive CPU_RESET; the CPU shares RESET externally.

Verification
REQ-025 LOAD addr=8'h03 data=16'hA5C3 -> one cycle PMEM_WE=1, PMEM_ADDR=3, PMEM_WDATA=A5C3; next cycle RSP_VALID=1, RSP_DATA=A5C3.
REQ-026 RUN with CPU model holding RDY=1, dropping RDY 1 cycle after START, raising it after 10 cycles -> exactly one START cycle; RSP_DATA=11, RSP_ERR=0.
REQ-027 PEEK addr=8'h20 with DMEM[0x20]=8'h7E -> DMEM_RE pulse at addr 0x20; RSP_DATA=16'h007E two cycles after accept.
REQ-028 RUN with TIMEOUT_CYCLES=20 and RDY never returning -> CPU_RESET one cycle; RSP_ERR=1, RSP_DATA=20.
REQ-029 RESET asserted during WAIT_DONE -> next cycle BUSY=0, CMD_READY=1, no RSP_VALID, CPU_START=0.
REQ-030 Back-to-back LOAD, RUN, PEEK with CMD_VALID held continuously -> each accepted only in IDLE, three responses in order, none dropped.

Source files
------------

// File: rtl/run_controller.sv
// rtl/run_controller.sv - host command sequencer for program load, CPU run with watchdog, and data peek
module run_controller #(
    parameter int PMEM_AW        = 8,
    parameter int DMEM_AW        = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [1:0]         CMD_OP,
    input  logic [7:0]         CMD_ADDR,
    input  logic [15:0]        CMD_DATA,
    output logic               RSP_VALID,
    output logic [15:0]        RSP_DATA,
    output logic               RSP_ERR,
    output logic               CPU_START,
    input  logic               CPU_RDY,
    output logic               PMEM_WE,
    output logic [PMEM_AW-1:0] PMEM_ADDR,
    output logic [15:0]        PMEM_WDATA,
    output logic               DMEM_RE,
    output logic [DMEM_AW-1:0] DMEM_ADDR,
    input  logic [7:0]         DMEM_RDATA,
    output logic               CPU_RESET,
    output logic               BUSY
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_KICK, S_WAIT_LEAVE, S_WAIT_DONE, S_PEEK, S_PEEK_RSP, S_ABORT
    } state_t;

    localparam logic [1:0]  OP_LOAD = 2'b00;
    localparam logic [1:0]  OP_RUN  = 2'b01;
    localparam logic [1:0]  OP_PEEK = 2'b10;
    localparam logic [31:0] LP_TIMEOUT = TIMEOUT_CYCLES;

    state_t      r_state, w_next;
    logic [7:0]  r_addr;
    logic [15:0] r_data;
    logic [15:0] r_cnt;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_data;
    logic        r_rsp_err;

    logic        w_accept;
    logic [15:0] w_cnt_inc;
    logic        w_timeout;
    logic        w_rsp_fire;
    logic [15:0] w_rsp_data;
    logic        w_rsp_err;

    assign w_accept  = CMD_VALID && (r_state == S_IDLE);
    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign w_timeout = ({16'h0000, w_cnt_inc} >= LP_TIMEOUT);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_rsp_valid <= w_rsp_fire;
            if (w_rsp_fire) begin
                r_rsp_data <= w_rsp_data;
                r_rsp_err  <= w_rsp_err;
            end
            if (w_accept) begin
                r_addr <= CMD_ADDR;
                r_data <= CMD_DATA;
            end
            if (w_accept && (CMD_OP == OP_RUN))
                r_cnt <= '0;
            else if ((r_state == S_WAIT_LEAVE) || (r_state == S_WAIT_DONE))
                r_cnt <= w_cnt_inc;
        end
    end

    // Completion wins over the watchdog in the cycle RDY returns; the reported count includes that cycle.
    always_comb begin
        w_next     = r_state;
        w_rsp_fire = 1'b0;
        w_rsp_data = r_rsp_data;
        w_rsp_err  = r_rsp_err;
        case (r_state)
            S_IDLE: begin
                if (CMD_VALID) begin
                    case (CMD_OP)
                        OP_LOAD: w_next = S_LOAD;
                        OP_RUN:  w_next = S_KICK;
                        OP_PEEK: w_next = S_PEEK;
                        default: begin
                            w_rsp_fire = 1'b1;
                            w_rsp_data = 16'h0000;
                            w_rsp_err  = 1'b0;
                        end
                    endcase
                end
            end
            S_LOAD: begin
                w_next     = S_IDLE;
                w_rsp_fire = 1'b1;
                w_rsp_data = r_data;
                w_rsp_err  = 1'b0;
            end
            S_KICK: if (CPU_RDY) w_next = S_WAIT_LEAVE;
            S_WAIT_LEAVE: begin
                if (w_timeout)     w_next = S_ABORT;
                else if (!CPU_RDY) w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (CPU_RDY) begin
                    w_next     = S_IDLE;
                    w_rsp_fire = 1'b1;
                    w_rsp_data = w_cnt_inc;
                    w_rsp_err  = 1'b0;
                end else if (w_timeout) begin
                    w_next = S_ABORT;
                end
            end
            S_PEEK: w_next = S_PEEK_RSP;
            S_PEEK_RSP: begin
                w_next     = S_IDLE;
                w_rsp_fire = 1'b1;
                w_rsp_data = {8'h00, DMEM_RDATA};
                w_rsp_err  = 1'b0;
            end
            S_ABORT: begin
                w_next     = S_IDLE;
                w_rsp_fire = 1'b1;
                w_rsp_data = r_cnt;
                w_rsp_err  = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Every output is forced low while RESET is high, whatever state is registered.
    always_comb begin
        CMD_READY  = !RESET && (r_state == S_IDLE);
        BUSY       = !RESET && (r_state != S_IDLE);
        PMEM_WE    = !RESET && (r_state == S_LOAD);
        DMEM_RE    = !RESET && (r_state == S_PEEK);
        CPU_START  = !RESET && (r_state == S_KICK);
        CPU_RESET  = !RESET && (r_state == S_ABORT);
        PMEM_ADDR  = PMEM_WE ? PMEM_AW'(r_addr) : '0;
        PMEM_WDATA = PMEM_WE ? r_data : 16'h0000;
        DMEM_ADDR  = DMEM_RE ? DMEM_AW'(r_addr) : '0;
        RSP_VALID  = !RESET && r_rsp_valid;
        RSP_DATA   = RESET ? 16'h0000 : r_rsp_data;
        RSP_ERR    = !RESET && r_rsp_err;
    end
endmodule

// File: tb/tb_run_controller.sv
// tb/tb_run_controller.sv - self-checking bench for run_controller
module tb_run_controller;
    localparam int PAW = 6;
    localparam int DAW = 8;
    localparam int TMO = 20;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [1:0]     cmd_op = 2'b11;
    logic [7:0]     cmd_addr = '0;
    logic [15:0]    cmd_data = '0;
    logic           rsp_valid;
    logic [15:0]    rsp_data;
    logic           rsp_err;
    logic           cpu_start;
    logic           cpu_rdy = 1'b1;
    logic           pmem_we;
    logic [PAW-1:0] pmem_addr;
    logic [15:0]    pmem_wdata;
    logic           dmem_re;
    logic [DAW-1:0] dmem_addr;
    logic [7:0]     dmem_rdata = '0;
    logic           cpu_reset;
    logic           busy;

    run_controller #(.PMEM_AW(PAW), .DMEM_AW(DAW), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(clk), .RESET(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .CMD_OP(cmd_op), .CMD_ADDR(cmd_addr), .CMD_DATA(cmd_data),
        .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err),
        .CPU_START(cpu_start), .CPU_RDY(cpu_rdy),
        .PMEM_WE(pmem_we), .PMEM_ADDR(pmem_addr), .PMEM_WDATA(pmem_wdata),
        .DMEM_RE(dmem_re), .DMEM_ADDR(dmem_addr), .DMEM_RDATA(dmem_rdata),
        .CPU_RESET(cpu_reset), .BUSY(busy)
    );

    always #5 clk = ~clk;

    logic [7:0] dmem [256];
    always @(posedge clk) if (dmem_re) dmem_rdata <= dmem[dmem_addr];

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [15:0] data;
        int          a;   // cycles RDY stays low while START is up
        int          b;   // extra cycles RDY stays high after START
        int          d;   // cycles RDY is low during the run, <0 = never returns
    } cmd_t;

    cmd_t        cq[$];
    logic [16:0] eq[$];
    logic [21:0] pmem_exp[$];
    logic [7:0]  dmem_exp[$];
    int          exp_starts, exp_resets;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] model(input cmd_t c);
        int total;
        case (c.op)
            2'b00: return {1'b0, c.data};
            2'b01: begin
                total = c.b + 1 + c.d;
                if (c.d < 0 || total > TMO) return {1'b1, 16'(TMO)};
                return {1'b0, 16'(total)};
            end
            2'b10: return {1'b0, 8'h00, dmem[c.addr]};
            default: return 17'h0;
        endcase
    endfunction

    function automatic logic sched(input cmd_t c, input int k);
        if (k < c.a) return 1'b0;
        if (k < c.a + 1 + c.b) return 1'b1;
        if (c.d < 0 || k < c.a + 1 + c.b + c.d) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push(input logic [1:0] op, input logic [7:0] addr, input logic [15:0] data,
                        input int a, input int b, input int d);
        cmd_t c;
        c.op = op; c.addr = addr; c.data = data; c.a = a; c.b = b; c.d = d;
        cq.push_back(c);
        eq.push_back(model(c));
        if (op == 2'b00) pmem_exp.push_back({addr[PAW-1:0], data});
        if (op == 2'b10) dmem_exp.push_back(addr);
        if (op == 2'b01) begin
            exp_starts += a + 1;
            if (model(c) >= 17'h10000) exp_resets++;
        end
    endtask

    // Drives queued commands with CMD_VALID held (optional idle gaps), plays the CPU, scores responses.
    task automatic play(input string tag, input bit gaps, input int budget);
        cmd_t cur, rc;
        bit   have = 0, run_act = 0, last_acc = 0, excl_bad = 0, ready_bad = 0;
        int   k = 0, starts = 0, resets = 0;
        for (int cyc = 0; cyc < budget && (cq.size() > 0 || eq.size() > 0 || have); cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (eq.size() == 0) chk({tag, "_rsp_extra"}, 1, 0);
                else chk({tag, "_rsp"}, {15'h0, rsp_err, rsp_data}, {15'h0, eq.pop_front()});
                run_act = 0;
            end
            if (pmem_we) begin
                if (pmem_exp.size() == 0) chk({tag, "_pmem_extra"}, 1, 0);
                else chk({tag, "_pmem_wr"}, {pmem_addr, pmem_wdata}, pmem_exp.pop_front());
            end
            if (dmem_re) begin
                if (dmem_exp.size() == 0) chk({tag, "_dmem_extra"}, 1, 0);
                else chk({tag, "_dmem_addr"}, dmem_addr, dmem_exp.pop_front());
            end
            if (cpu_start) starts++;
            if (cpu_reset) resets++;
            if (32'(pmem_we) + 32'(dmem_re) + 32'(cpu_start) + 32'(cpu_reset) > 1) excl_bad = 1;
            if (cmd_ready === busy) ready_bad = 1;
            if (last_acc) begin
                if (cur.op == 2'b01) begin run_act = 1; k = 0; rc = cur; end
                have = 0;
            end
            if (run_act) begin cpu_rdy = sched(rc, k); k++; end
            else cpu_rdy = 1'b1;
            if (!have && cq.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
                cur = cq.pop_front();
                have = 1;
            end
            cmd_valid = have;
            cmd_op    = have ? cur.op : 2'b11;
            cmd_addr  = have ? cur.addr : 8'h00;
            cmd_data  = have ? cur.data : 16'h0000;
            last_acc  = cmd_valid && cmd_ready;
        end
        cmd_valid = 0;
        chk({tag, "_left_rsp"}, eq.size() + cq.size(), 0);
        chk({tag, "_starts"}, starts, exp_starts);
        chk({tag, "_cpu_resets"}, resets, exp_resets);
        chk({tag, "_exclusive"}, excl_bad, 0);
        chk({tag, "_ready_iff_idle"}, ready_bad, 0);
        exp_starts = 0; exp_resets = 0;
    endtask

    initial begin
        exp_starts = 0; exp_resets = 0;
        for (int i = 0; i < 256; i++) dmem[i] = 8'($urandom);
        dmem[8'h20] = 8'h7E;

        // reset: all outputs low while RESET is high, then idle and ready
        @(negedge clk);
        chk("rst_flags", {cmd_ready, busy, rsp_valid, rsp_err, cpu_start, cpu_reset, pmem_we, dmem_re}, 0);
        chk("rst_buses", {rsp_data, pmem_wdata}, 0);
        rst = 0;
        #1;
        chk("post_rst_flags", {cmd_ready, busy, rsp_valid, rsp_err, cpu_start, cpu_reset, pmem_we, dmem_re}, 8'h80);

        // single LOAD with exact timing
        cmd_valid = 1; cmd_op = 2'b00; cmd_addr = 8'h03; cmd_data = 16'hA5C3;
        @(negedge clk); cmd_valid = 0;
        chk("load_we", {pmem_we, busy, cmd_ready}, 3'b110);
        chk("load_addr", pmem_addr, 3);
        chk("load_wdata", pmem_wdata, 16'hA5C3);
        @(negedge clk);
        chk("load_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b10, 16'hA5C3});
        @(negedge clk);
        chk("load_rsp_hold", {rsp_valid, rsp_err, rsp_data}, {2'b00, 16'hA5C3});

        // PEEK: read strobe one cycle, response after the capture cycle
        cmd_valid = 1; cmd_op = 2'b10; cmd_addr = 8'h20;
        @(negedge clk); cmd_valid = 0;
        chk("peek_re", {dmem_re, dmem_addr}, {1'b1, 8'h20});
        @(negedge clk);
        chk("peek_wait", {dmem_re, rsp_valid}, 0);
        @(negedge clk);
        chk("peek_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b10, 16'h007E});

        // NOP: immediate zero response, never busy
        cmd_valid = 1; cmd_op = 2'b11;
        @(negedge clk); cmd_valid = 0;
        chk("nop_rsp", {rsp_valid, busy, rsp_data}, {2'b10, 16'h0000});

        push(2'b01, 8'h00, 16'h0, 0, 0, 10);
        play("run11", 0, 60);
        push(2'b01, 8'h00, 16'h0, 1, 0, -1);
        play("timeout", 0, 60);
        push(2'b00, 8'hFF, 16'h1234, 0, 0, 0);
        push(2'b10, 8'hFF, 16'h0, 0, 0, 0);
        play("addr_ff", 0, 20);
        push(2'b00, 8'h11, 16'hC0DE, 0, 0, 0);
        push(2'b01, 8'h00, 16'h0, 0, 2, 3);
        push(2'b10, 8'h42, 16'h0, 0, 0, 0);
        play("b2b", 0, 60);
        for (int i = 0; i < 40; i++)
            push(2'($urandom_range(0, 3)), 8'($urandom), 16'($urandom),
                 $urandom_range(0, 2), $urandom_range(0, 3),
                 ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(1, 12));
        play("rand", 1, 3000);

        // RESET in the middle of a run
        push(2'b00, 8'h05, 16'hBEEF, 0, 0, 0);
        play("pre_rst", 0, 20);
        cmd_valid = 1; cmd_op = 2'b01;
        @(negedge clk); cmd_valid = 0; cpu_rdy = 1;
        @(negedge clk); cpu_rdy = 0;
        @(negedge clk);
        @(negedge clk);
        chk("midrun_busy", {busy, cpu_start, rsp_data}, {2'b10, 16'hBEEF});
        rst = 1;
        #1;
        chk("midrun_rst_outs", {cmd_ready, busy, rsp_valid, rsp_err, cpu_start, cpu_reset, 16'(rsp_data)}, 0);
        @(negedge clk); rst = 0; cpu_rdy = 1;
        #1;
        chk("midrun_after", {busy, cmd_ready, rsp_valid, cpu_start, cpu_reset}, 5'b01000);
        chk("midrun_rsp_clr", {rsp_err, rsp_data}, 0);
        @(negedge clk);
        chk("midrun_quiet", {busy, rsp_valid, cpu_start, cpu_reset}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
